vpp_multi: RTL and testbench
============================

Name: vpp_multi

Overview:
- Multi-channel successor to the single-channel peak-to-peak meter.
- Tracks running max/min per channel over a window of N accepted samples.
- At window end, publishes max, min and vpp = max − min for all channels atomically, then raises a sticky interrupt.
- Adds sample-enable gating, run-time window length, signed mode and overrun detection; sits after the ADC capture stage and feeds the measurement register bank.

Parameters:
- DATA_W, 12, bits per channel sample
- CHANNELS, 4, number of channels packed on data_u
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare
- POINTS, 200, window length used when win_len input is 0

Ports:
- clk_fs  in  1  sample clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  sample accept strobe; data_u is consumed only on cycles with en=1
- data_u  in  CHANNELS*DATA_W  packed samples, channel k at bits [k*DATA_W +: DATA_W]
- win_len  in  32  window length in accepted samples; 0 selects POINTS
- irq_clr  in  1  clears irq and overrun
- max  out  CHANNELS*DATA_W  per-channel window maximum, same packing
- min  out  CHANNELS*DATA_W  per-channel window minimum
- vpp  out  CHANNELS*DATA_W  per-channel max − min, always unsigned
- done  out  1  one-cycle pulse when results update
- irq  out  1  sticky result-ready flag
- overrun  out  1  sticky: results updated while irq was still set
- win_cnt  out  32  accepted samples so far in the current window

Behaviour:
- Clock is clk_fs. Reset rst_n is synchronous and active-low: all state is evaluated on the rising edge of clk_fs only.
- Reset values: max, min, vpp, win_cnt, running registers and latched length are 0; done, irq and overrun are 0.
- Window length:
  - The effective length L is latched on the accepted sample where win_cnt = 0.
  - L = win_len, or POINTS if win_len = 0. Values of 1 are clamped to 2.
  - Changing win_len mid-window has no effect until the next window.
- Per accepted sample (en=1):
  - win_cnt = 0: running max and min are seeded with the current sample. No carry-over from the previous window.
  - 0 < win_cnt < L−1: running max and min update with the current sample.
  - win_cnt = L−1: the current sample is folded in and the final result is written directly to the max, min and vpp outputs on this same edge. win_cnt returns to 0.
- Cycles with en=0 hold all state, including win_cnt. done is 0 on those cycles.
- Compare mode:
  - SIGNED=1: comparisons use two's-complement; vpp is computed in DATA_W+1 bits and the low DATA_W bits are output. The result is exact because max ≥ min.
  - SIGNED=0: comparisons are plain unsigned.
- Latency: the outputs change at the edge that accepts sample L−1 and are visible from the next cycle. done is high for exactly that one following cycle.
- irq:
  - Set at the update edge.
  - Cleared on an edge with irq_clr=1 and no update.
  - Update and irq_clr on the same edge leaves irq=1.
- overrun:
  - Set at an update edge when irq is already 1 and irq_clr=0.
  - Cleared by irq_clr unless an overrun-setting update occurs on that same edge.
- max, min and vpp hold their values between updates. All channels always update together.
- Reset asserted mid-window:
  - The partial window is discarded and outputs return to 0.
  - The first accepted sample after reset release starts a new window.

Test Plan:
- Unsigned, CHANNELS=2, win_len=4, en=1 every cycle.
  - Stimulus: ch0 = 5, 9, 2, 7; ch1 = 100, 100, 100, 100.
  - Required: max = {100, 9}, min = {100, 2}, vpp = {0, 7}; done pulses once, on the cycle after the 4th sample; irq=1.
- Window seeding: continue with next window ch0 = 50, 51, 52, 53.
  - Required: min ch0 = 50, not 2 and not 7; vpp ch0 = 3.
- SIGNED=1, DATA_W=12, win_len=3, ch0 = 0x800 (−2048), 0x7FF (+2047), 0x000.
  - Required: max = 0x7FF, min = 0x800, vpp = 0xFFF.
- en gating: win_len=4 with en toggled 1,0,0,1,1,0,1.
  - Required: update only after the 4th accepted sample; win_cnt holds during en=0 cycles.
- irq handling and window-length changes:
  - Complete two windows without irq_clr: overrun=1 after the second.
  - Assert irq_clr alone: irq=0 and overrun=0.
  - Assert irq_clr on an update edge: irq stays 1.
  - win_len=0: a window takes 200 samples. win_len=1: a window takes 2 samples.
- Reset mid-window: with win_len=10, assert rst_n=0 after sample 5 for 1 cycle.
  - Required: all outputs read 0; the next full 10 samples produce a correct result; done does not pulse early.

Source files
------------

// File: rtl/vpp_multi_if.sv
// vpp_multi_if: sample/result bundle for the multi-channel peak-to-peak meter.
//   master  : producer side (ADC capture / register bank) drives en, data_u,
//             win_len, irq_clr and observes the results.
//   slave   : the meter itself; consumes samples, publishes max/min/vpp,
//             done, irq, overrun and win_cnt.
// Channel k of every packed vector lives at bits [k*DATA_W +: DATA_W].
interface vpp_multi_if #(
  parameter int DATA_W   = 12,
  parameter int CHANNELS = 4
) ();
  logic                         en;
  logic [CHANNELS*DATA_W-1:0]   data_u;
  logic [31:0]                  win_len;
  logic                         irq_clr;
  logic [CHANNELS*DATA_W-1:0]   max;
  logic [CHANNELS*DATA_W-1:0]   min;
  logic [CHANNELS*DATA_W-1:0]   vpp;
  logic                         done;
  logic                         irq;
  logic                         overrun;
  logic [31:0]                  win_cnt;

  modport master (
    output en, data_u, win_len, irq_clr,
    input  max, min, vpp, done, irq, overrun, win_cnt
  );

  modport slave (
    input  en, data_u, win_len, irq_clr,
    output max, min, vpp, done, irq, overrun, win_cnt
  );
endinterface

// File: rtl/vpp_multi.sv
// vpp_multi: per-channel running max/min over a window of L accepted samples.
// At the sample that closes the window, max, min and vpp of all channels are
// published together, done pulses for one cycle and the sticky irq is set.
// Ports:
//   clk_fs  sample clock
//   rst_n   synchronous active-low reset
//   bus     vpp_multi_if.slave (en, data_u, win_len, irq_clr in;
//           max, min, vpp, done, irq, overrun, win_cnt out)
module vpp_multi #(
  parameter int DATA_W   = 12,
  parameter int CHANNELS = 4,
  parameter int SIGNED   = 0,
  parameter int POINTS   = 200
) (
  input  logic         clk_fs,
  input  logic         rst_n,
  vpp_multi_if.slave   bus
);
  localparam int W = CHANNELS * DATA_W;

  logic [31:0]  win_cnt_q, win_cnt_d;
  logic [31:0]  len_q, len_d;
  logic [W-1:0] run_max_q, run_max_d;
  logic [W-1:0] run_min_q, run_min_d;
  logic [W-1:0] max_q, max_d;
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] vpp_q, vpp_d;
  logic         done_q, done_d;
  logic         irq_q, irq_d;
  logic         ovr_q, ovr_d;

  logic         seed;
  logic [31:0]  eff_len;
  logic [31:0]  cur_len;
  logic         last;
  logic [W-1:0] fold_max, fold_min, fold_vpp;

  assign seed = (win_cnt_q == 32'd0);

  // Window length as it would be latched now; 1 is clamped to 2 so the first
  // sample can never also be the closing one.
  always_comb begin
    if (bus.win_len == 32'd0)      eff_len = 32'(POINTS);
    else if (bus.win_len == 32'd1) eff_len = 32'd2;
    else                           eff_len = bus.win_len;
  end

  // On the seeding sample the length is not latched yet, so use it directly.
  assign cur_len = seed ? eff_len : len_q;
  assign last    = (win_cnt_q == cur_len - 32'd1);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DATA_W-1:0] s, rmax, rmin, nmax, nmin;
    logic              gt_max, lt_min;

    assign s    = bus.data_u[k*DATA_W +: DATA_W];
    assign rmax = run_max_q[k*DATA_W +: DATA_W];
    assign rmin = run_min_q[k*DATA_W +: DATA_W];

    if (SIGNED != 0) begin : g_signed
      assign gt_max = $signed(s) > $signed(rmax);
      assign lt_min = $signed(s) < $signed(rmin);
    end else begin : g_unsigned
      assign gt_max = s > rmax;
      assign lt_min = s < rmin;
    end

    assign nmax = (seed || gt_max) ? s : rmax;
    assign nmin = (seed || lt_min) ? s : rmin;

    assign fold_max[k*DATA_W +: DATA_W] = nmax;
    assign fold_min[k*DATA_W +: DATA_W] = nmin;
    // max >= min in the active compare mode, so the true difference fits in
    // DATA_W unsigned bits and the modular DATA_W-bit subtraction is exact.
    assign fold_vpp[k*DATA_W +: DATA_W] = nmax - nmin;
  end

  always_comb begin
    win_cnt_d = win_cnt_q;
    len_d     = len_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    max_d     = max_q;
    min_d     = min_q;
    vpp_d     = vpp_q;
    done_d    = 1'b0;
    irq_d     = irq_q;
    ovr_d     = ovr_q;

    if (bus.en) begin
      run_max_d = fold_max;
      run_min_d = fold_min;
      if (seed) len_d = eff_len;
      if (last) begin
        win_cnt_d = 32'd0;
        max_d     = fold_max;
        min_d     = fold_min;
        vpp_d     = fold_vpp;
        done_d    = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 32'd1;
      end
    end

    // An update always wins over irq_clr for irq; overrun is only flagged
    // when the previous result was never acknowledged.
    if (done_d)           irq_d = 1'b1;
    else if (bus.irq_clr) irq_d = 1'b0;

    if (done_d && irq_q && !bus.irq_clr) ovr_d = 1'b1;
    else if (bus.irq_clr)                ovr_d = 1'b0;
  end

  always_ff @(posedge clk_fs) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      len_q     <= '0;
      run_max_q <= '0;
      run_min_q <= '0;
      max_q     <= '0;
      min_q     <= '0;
      vpp_q     <= '0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      len_q     <= len_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      max_q     <= max_d;
      min_q     <= min_d;
      vpp_q     <= vpp_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.max     = max_q;
  assign bus.min     = min_q;
  assign bus.vpp     = vpp_q;
  assign bus.done    = done_q;
  assign bus.irq     = irq_q;
  assign bus.overrun = ovr_q;
  assign bus.win_cnt = win_cnt_q;
endmodule

// File: tb/tb_vpp_multi.sv
// Directed bench for vpp_multi: an unsigned 2-channel instance and a signed
// 2-channel instance share clock and reset.
module tb_vpp_multi;
  logic clk_fs = 1'b0;
  logic rst_n  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_fs = ~clk_fs;

  vpp_multi_if #(.DATA_W(12), .CHANNELS(2)) if_u ();
  vpp_multi_if #(.DATA_W(12), .CHANNELS(2)) if_s ();

  vpp_multi #(.DATA_W(12), .CHANNELS(2), .SIGNED(0), .POINTS(200)) dut_u (
    .clk_fs(clk_fs), .rst_n(rst_n), .bus(if_u.slave));
  vpp_multi #(.DATA_W(12), .CHANNELS(2), .SIGNED(1), .POINTS(200)) dut_s (
    .clk_fs(clk_fs), .rst_n(rst_n), .bus(if_s.slave));

  task automatic step_u(input logic [11:0] c0, input logic [11:0] c1, input logic e);
    if_u.en     = e;
    if_u.data_u = {c1, c0};
    @(posedge clk_fs);
    #1;
    if_u.en = 1'b0;
  endtask

  task automatic step_s(input logic [11:0] c0, input logic [11:0] c1, input logic e);
    if_s.en     = e;
    if_s.data_u = {c1, c0};
    @(posedge clk_fs);
    #1;
    if_s.en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_fs);
    #1;
    checks++; if (if_u.max !== 24'h0) begin errors++; $display("FAIL reset_max got=%h exp=0", if_u.max); end
    checks++; if (if_u.min !== 24'h0) begin errors++; $display("FAIL reset_min got=%h exp=0", if_u.min); end
    checks++; if (if_u.vpp !== 24'h0) begin errors++; $display("FAIL reset_vpp got=%h exp=0", if_u.vpp); end
    checks++; if ({if_u.done, if_u.irq, if_u.overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {if_u.done, if_u.irq, if_u.overrun}); end
    checks++; if (if_u.win_cnt !== 32'd0) begin errors++; $display("FAIL reset_win_cnt got=%0d exp=0", if_u.win_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    if_u.win_len = 32'd4;
    step_u(12'd5, 12'd100, 1'b1);
    step_u(12'd9, 12'd100, 1'b1);
    step_u(12'd2, 12'd100, 1'b1);
    checks++; if (if_u.done !== 1'b0 || if_u.win_cnt !== 32'd3) begin errors++; $display("FAIL basic_pre got done=%b cnt=%0d exp done=0 cnt=3", if_u.done, if_u.win_cnt); end
    step_u(12'd7, 12'd100, 1'b1);
    checks++; if (if_u.max !== 24'h064009) begin errors++; $display("FAIL basic_max got=%h exp=064009", if_u.max); end
    checks++; if (if_u.min !== 24'h064002) begin errors++; $display("FAIL basic_min got=%h exp=064002", if_u.min); end
    checks++; if (if_u.vpp !== 24'h000007) begin errors++; $display("FAIL basic_vpp got=%h exp=000007", if_u.vpp); end
    checks++; if (if_u.done !== 1'b1 || if_u.irq !== 1'b1 || if_u.win_cnt !== 32'd0) begin errors++; $display("FAIL basic_done got done=%b irq=%b cnt=%0d exp 1 1 0", if_u.done, if_u.irq, if_u.win_cnt); end
    step_u(12'd0, 12'd0, 1'b0);
    checks++; if (if_u.done !== 1'b0 || if_u.max !== 24'h064009) begin errors++; $display("FAIL basic_hold got done=%b max=%h exp done=0 max=064009", if_u.done, if_u.max); end
  endtask

  task automatic test_seeding;
    step_u(12'd50, 12'd10, 1'b1);
    step_u(12'd51, 12'd20, 1'b1);
    step_u(12'd52, 12'd30, 1'b1);
    step_u(12'd53, 12'd40, 1'b1);
    checks++; if (if_u.min !== 24'h00A032) begin errors++; $display("FAIL seed_min got=%h exp=00a032", if_u.min); end
    checks++; if (if_u.max !== 24'h028035) begin errors++; $display("FAIL seed_max got=%h exp=028035", if_u.max); end
    checks++; if (if_u.vpp !== 24'h01E003) begin errors++; $display("FAIL seed_vpp got=%h exp=01e003", if_u.vpp); end
    checks++; if (if_u.overrun !== 1'b1 || if_u.irq !== 1'b1) begin errors++; $display("FAIL seed_overrun got ovr=%b irq=%b exp 1 1", if_u.overrun, if_u.irq); end
  endtask

  task automatic test_irq_clr;
    if_u.irq_clr = 1'b1;
    step_u(12'd0, 12'd0, 1'b0);
    if_u.irq_clr = 1'b0;
    checks++; if (if_u.irq !== 1'b0 || if_u.overrun !== 1'b0) begin errors++; $display("FAIL irq_clr got irq=%b ovr=%b exp 0 0", if_u.irq, if_u.overrun); end
  endtask

  task automatic test_en_gating;
    logic [11:0] c0 [7] = '{12'd3, 12'd4095, 12'd4095, 12'd8, 12'd1, 12'd4095, 12'd6};
    logic [11:0] c1 [7] = '{12'd200, 12'd0, 12'd0, 12'd300, 12'd100, 12'd0, 12'd400};
    logic        e  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int          cnt [7] = '{1, 1, 1, 2, 3, 3, 0};
    logic        dn  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if_u.win_len = 32'd4;
    for (int i = 0; i < 7; i++) begin
      step_u(c0[i], c1[i], e[i]);
      checks++;
      if (if_u.win_cnt !== 32'(cnt[i]) || if_u.done !== dn[i]) begin
        errors++;
        $display("FAIL gate_step%0d got cnt=%0d done=%b exp cnt=%0d done=%b", i, if_u.win_cnt, if_u.done, cnt[i], dn[i]);
      end
    end
    checks++; if (if_u.max !== 24'h190008) begin errors++; $display("FAIL gate_max got=%h exp=190008", if_u.max); end
    checks++; if (if_u.min !== 24'h064001) begin errors++; $display("FAIL gate_min got=%h exp=064001", if_u.min); end
    checks++; if (if_u.vpp !== 24'h12C007) begin errors++; $display("FAIL gate_vpp got=%h exp=12c007", if_u.vpp); end
    checks++; if (if_u.irq !== 1'b1 || if_u.overrun !== 1'b0) begin errors++; $display("FAIL gate_irq got irq=%b ovr=%b exp 1 0", if_u.irq, if_u.overrun); end
  endtask

  task automatic test_clr_on_update;
    if_u.win_len = 32'd4;
    step_u(12'd10, 12'd7, 1'b1);
    if_u.win_len = 32'd2;
    step_u(12'd20, 12'd7, 1'b1);
    checks++; if (if_u.done !== 1'b0 || if_u.win_cnt !== 32'd2) begin errors++; $display("FAIL lenchg_mid got done=%b cnt=%0d exp 0 2", if_u.done, if_u.win_cnt); end
    step_u(12'd30, 12'd7, 1'b1);
    if_u.irq_clr = 1'b1;
    step_u(12'd40, 12'd7, 1'b1);
    if_u.irq_clr = 1'b0;
    checks++; if (if_u.done !== 1'b1 || if_u.vpp !== 24'h00001E) begin errors++; $display("FAIL lenchg_result got done=%b vpp=%h exp 1 00001e", if_u.done, if_u.vpp); end
    checks++; if (if_u.irq !== 1'b1 || if_u.overrun !== 1'b0) begin errors++; $display("FAIL clr_on_update got irq=%b ovr=%b exp 1 0", if_u.irq, if_u.overrun); end
    if_u.irq_clr = 1'b1;
    step_u(12'd0, 12'd0, 1'b0);
    if_u.irq_clr = 1'b0;
  endtask

  task automatic test_points;
    logic early = 1'b0;
    if_u.win_len = 32'd0;
    for (int i = 0; i < 199; i++) begin
      step_u(12'(i), 12'(199 - i), 1'b1);
      if (if_u.done !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0 || if_u.win_cnt !== 32'd199) begin errors++; $display("FAIL points_pre got early=%b cnt=%0d exp 0 199", early, if_u.win_cnt); end
    step_u(12'd199, 12'd0, 1'b1);
    checks++; if (if_u.done !== 1'b1 || if_u.vpp !== 24'h0C70C7) begin errors++; $display("FAIL points_result got done=%b vpp=%h exp 1 0c70c7", if_u.done, if_u.vpp); end
    checks++; if (if_u.max !== 24'h0C70C7 || if_u.min !== 24'h0) begin errors++; $display("FAIL points_maxmin got max=%h min=%h exp 0c70c7 0", if_u.max, if_u.min); end
  endtask

  task automatic test_len1;
    if_u.win_len = 32'd1;
    step_u(12'd4, 12'd0, 1'b1);
    checks++; if (if_u.done !== 1'b0 || if_u.win_cnt !== 32'd1) begin errors++; $display("FAIL len1_first got done=%b cnt=%0d exp 0 1", if_u.done, if_u.win_cnt); end
    step_u(12'd9, 12'd0, 1'b1);
    checks++; if (if_u.done !== 1'b1 || if_u.vpp !== 24'h000005 || if_u.min !== 24'h000004) begin errors++; $display("FAIL len1_result got done=%b vpp=%h min=%h exp 1 000005 000004", if_u.done, if_u.vpp, if_u.min); end
    checks++; if (if_u.overrun !== 1'b1) begin errors++; $display("FAIL len1_overrun got=%b exp=1", if_u.overrun); end
  endtask

  task automatic test_reset_mid;
    logic early = 1'b0;
    if_u.win_len = 32'd10;
    for (int i = 0; i < 5; i++) step_u(12'd3000, 12'd3000, 1'b1);
    rst_n = 1'b0;
    step_u(12'd0, 12'd0, 1'b0);
    rst_n = 1'b1;
    checks++; if (if_u.max !== 24'h0 || if_u.min !== 24'h0 || if_u.vpp !== 24'h0) begin errors++; $display("FAIL rstmid_outputs got max=%h min=%h vpp=%h exp 0", if_u.max, if_u.min, if_u.vpp); end
    checks++; if ({if_u.done, if_u.irq, if_u.overrun} !== 3'b000 || if_u.win_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_flags got flags=%b cnt=%0d exp 000 0", {if_u.done, if_u.irq, if_u.overrun}, if_u.win_cnt); end
    for (int i = 0; i < 9; i++) begin
      step_u(12'(20 + 3 * i), 12'(500 - i), 1'b1);
      if (if_u.done !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL rstmid_early got=%b exp=0", early); end
    step_u(12'd47, 12'd491, 1'b1);
    checks++; if (if_u.done !== 1'b1 || if_u.max !== 24'h1F402F) begin errors++; $display("FAIL rstmid_max got done=%b max=%h exp 1 1f402f", if_u.done, if_u.max); end
    checks++; if (if_u.min !== 24'h1EB014 || if_u.vpp !== 24'h00901B) begin errors++; $display("FAIL rstmid_minvpp got min=%h vpp=%h exp 1eb014 00901b", if_u.min, if_u.vpp); end
  endtask

  task automatic test_signed;
    if_s.win_len = 32'd3;
    step_s(12'h800, 12'hFFF, 1'b1);
    step_s(12'h7FF, 12'h001, 1'b1);
    step_s(12'h000, 12'hFFE, 1'b1);
    checks++; if (if_s.max !== 24'h0017FF) begin errors++; $display("FAIL signed_max got=%h exp=0017ff", if_s.max); end
    checks++; if (if_s.min !== 24'hFFE800) begin errors++; $display("FAIL signed_min got=%h exp=ffe800", if_s.min); end
    checks++; if (if_s.vpp !== 24'h003FFF || if_s.done !== 1'b1) begin errors++; $display("FAIL signed_vpp got vpp=%h done=%b exp 003fff 1", if_s.vpp, if_s.done); end
  endtask

  initial begin
    if_u.en = 1'b0; if_u.data_u = '0; if_u.win_len = 32'd4; if_u.irq_clr = 1'b0;
    if_s.en = 1'b0; if_s.data_u = '0; if_s.win_len = 32'd3; if_s.irq_clr = 1'b0;
    test_reset;
    test_basic;
    test_seeding;
    test_irq_clr;
    test_en_gating;
    test_clr_on_update;
    test_points;
    test_len1;
    test_reset_mid;
    test_signed;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
